// File: rtl/csr_access_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : csr_access_sequencer_if
// Purpose  : CSR bus between the access sequencer (master) and the CSR data
//            registers (slaves). The slaves OR their read data and hit flags.
// Revision : 1.0 - initial release
// ============================================================================
interface csr_access_sequencer_if;
  logic        csrWriteEnable;
  logic        csrReadEnable;
  logic [11:0] csrAddress;
  logic [31:0] csrWriteData;
  logic [31:0] csrReadData;
  logic        csrRequestOutput;

  modport master (
    output csrWriteEnable,
    output csrReadEnable,
    output csrAddress,
    output csrWriteData,
    input  csrReadData,
    input  csrRequestOutput
  );

  modport slave (
    input  csrWriteEnable,
    input  csrReadEnable,
    input  csrAddress,
    input  csrWriteData,
    output csrReadData,
    output csrRequestOutput
  );
endinterface
`default_nettype wire

// File: rtl/csr_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : csr_access_sequencer
// Purpose  : Executes one Zicsr operation (CSRRW/CSRRS/CSRRC, register or
//            immediate form) per core request: optional read, optional
//            read-modify-write, illegal-access detection, old value return.
// Revision : 1.0 - initial release
// ============================================================================
module csr_access_sequencer (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          request,
  input  logic [1:0]                    op,
  input  logic [11:0]                   address,
  input  logic [31:0]                   sourceData,
  input  logic                          sourceIsZero,
  input  logic                          destIsZero,
  output logic                          busy,
  output logic                          done,
  output logic                          illegal,
  output logic [31:0]                   result,
  csr_access_sequencer_if.master        bus
);

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q,    state_d;
  logic [1:0]  op_q,       op_d;
  logic [31:0] src_q,      src_d;
  logic        do_write_q, do_write_d;
  logic        illegal_q,  illegal_d;
  logic [31:0] result_q,   result_d;
  logic [11:0] addr_q,     addr_d;
  logic [31:0] wdata_q,    wdata_d;

  logic w_do_read;
  logic w_do_write;
  logic w_read_only;

  // Access classification of the incoming request (only meaningful in IDLE)
  always_comb begin
    w_do_read   = !((op == OP_RW) && destIsZero);
    w_do_write  = (op == OP_RW) || !sourceIsZero;
    w_read_only = (address[11:10] == 2'b11);
  end

  // Next-state and datapath update; result_q doubles as the captured old value
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src_d      = src_q;
    do_write_d = do_write_q;
    illegal_d  = illegal_q;
    result_d   = result_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        if (request) begin
          op_d       = op;
          src_d      = sourceData;
          do_write_d = w_do_write;
          result_d   = '0;
          illegal_d  = 1'b0;
          if ((op == 2'b00) || (w_do_write && w_read_only)) begin
            illegal_d = 1'b1;
            state_d   = DONE;
          end else begin
            addr_d = address;
            if (w_do_read) begin
              state_d = READ;
            end else begin
              wdata_d = sourceData;
              state_d = WRITE;
            end
          end
        end
      end
      READ: begin
        result_d = bus.csrReadData;
        if (!bus.csrRequestOutput) begin
          illegal_d = 1'b1;
          state_d   = DONE;
        end else if (do_write_q) begin
          case (op_q)
            OP_RS:   wdata_d = bus.csrReadData | src_q;
            OP_RC:   wdata_d = bus.csrReadData & ~src_q;
            default: wdata_d = src_q;
          endcase
          state_d = WRITE;
        end else begin
          state_d = DONE;
        end
      end
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= 2'b00;
      src_q      <= '0;
      do_write_q <= 1'b0;
      illegal_q  <= 1'b0;
      result_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src_q      <= src_d;
      do_write_q <= do_write_d;
      illegal_q  <= illegal_d;
      result_q   <= result_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Strobes and status decode from the state register only
  always_comb begin
    busy               = (state_q != IDLE);
    done               = (state_q == DONE);
    illegal            = (state_q == DONE) && illegal_q;
    result             = result_q;
    bus.csrReadEnable  = (state_q == READ);
    bus.csrWriteEnable = (state_q == WRITE);
    bus.csrAddress     = addr_q;
    bus.csrWriteData   = wdata_q;
  end

endmodule
`default_nettype wire
